// File: rtl/gbt_link_supervisor.sv
// gbt_link_supervisor: GBT link bring-up sequencer on the 120 MHz domain.
// Qualifies the link as UP after a stable period, requests a global reset
// when acquisition times out, and keeps saturating event counters plus a
// sticky interrupt flag for the PS status register file.
module gbt_link_supervisor #(
    parameter int g_tick_div        = 120000,
    parameter int g_stable_ms       = 10,
    parameter int g_lock_timeout_ms = 2400,
    parameter int g_holdoff_ms      = 5
) (
    input  logic        clk_ik,
    input  logic        rst_ir,
    input  logic        pll_locked_i,
    input  logic        rx_ready_i,
    input  logic        tx_ready_i,
    input  logic        los_i,
    input  logic        clear_i,
    output logic        link_up_o,
    output logic [1:0]  state_o,
    output logic        reset_req_o,
    output logic [15:0] loss_count_o,
    output logic [15:0] reset_count_o,
    output logic [15:0] last_lock_ms_o,
    output logic        irq_o
);

    localparam logic [1:0] S_WAIT_PLL = 2'd0;
    localparam logic [1:0] S_ACQUIRE  = 2'd1;
    localparam logic [1:0] S_UP       = 2'd2;
    localparam logic [1:0] S_HOLDOFF  = 2'd3;

    localparam int              DIV_W       = (g_tick_div > 1) ? $clog2(g_tick_div) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(g_tick_div - 1);
    localparam logic [15:0]     STABLE_TGT  = 16'(g_stable_ms);
    localparam logic [15:0]     TIMEOUT_TGT = 16'(g_lock_timeout_ms);
    localparam logic [15:0]     HOLDOFF_TGT = 16'(g_holdoff_ms);

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_state;
    logic [15:0]      r_acqMs;
    logic [15:0]      r_stableCnt;
    logic [15:0]      r_holdCnt;
    logic             r_linkUp;
    logic             r_resetReq;
    logic [15:0]      r_lossCount;
    logic [15:0]      r_resetCount;
    logic [15:0]      r_lastLockMs;
    logic             r_irq;

    logic        w_tick;
    logic        w_good;
    logic [15:0] w_acqInc;
    logic [15:0] w_stableInc;
    logic [1:0]  w_stateNxt;
    logic [15:0] w_acqNxt;
    logic [15:0] w_stableNxt;
    logic [15:0] w_holdNxt;
    logic        w_enterUp;
    logic        w_timeout;
    logic        w_loss;
    logic [15:0] w_lossNxt;
    logic [15:0] w_resetCntNxt;
    logic [15:0] w_lastLockNxt;
    logic        w_irqNxt;

    assign w_tick      = (r_div == DIV_LAST);
    assign w_good      = pll_locked_i & rx_ready_i & tx_ready_i & ~los_i;
    assign w_acqInc    = satInc(r_acqMs);
    assign w_stableInc = satInc(r_stableCnt);

    // Free-running 1 ms tick divider
    always_ff @(posedge clk_ik) begin
        if (rst_ir || w_tick) r_div <= '0;
        else                  r_div <= r_div + DIV_W'(1);
    end

    // Bring-up sequence: next state, acquisition/stable/holdoff counters and event strobes
    always_comb begin
        w_stateNxt  = r_state;
        w_acqNxt    = r_acqMs;
        w_stableNxt = r_stableCnt;
        w_holdNxt   = r_holdCnt;
        w_enterUp   = 1'b0;
        w_timeout   = 1'b0;
        w_loss      = 1'b0;
        case (r_state)
            S_WAIT_PLL: begin
                if (pll_locked_i) begin
                    w_stateNxt  = S_ACQUIRE;
                    w_acqNxt    = '0;
                    w_stableNxt = '0;
                end
            end
            S_ACQUIRE: begin
                if (!pll_locked_i) begin
                    w_stateNxt = S_WAIT_PLL;
                end else begin
                    if (!w_good)     w_stableNxt = '0;
                    else if (w_tick) w_stableNxt = w_stableInc;
                    if (w_tick)      w_acqNxt    = w_acqInc;
                    // A stable-complete tick takes precedence over a timeout on the same tick
                    if (w_good && w_tick && (w_stableInc == STABLE_TGT)) begin
                        w_stateNxt = S_UP;
                        w_enterUp  = 1'b1;
                    end else if (w_tick && (w_acqInc == TIMEOUT_TGT)) begin
                        w_stateNxt = S_HOLDOFF;
                        w_timeout  = 1'b1;
                        w_holdNxt  = '0;
                    end
                end
            end
            S_UP: begin
                if (!w_good) begin
                    w_loss = 1'b1;
                    if (!pll_locked_i) begin
                        w_stateNxt = S_WAIT_PLL;
                    end else begin
                        w_stateNxt  = S_ACQUIRE;
                        w_acqNxt    = '0;
                        w_stableNxt = '0;
                    end
                end
            end
            default: begin
                if (w_tick) begin
                    w_holdNxt = satInc(r_holdCnt);
                    if (satInc(r_holdCnt) == HOLDOFF_TGT) w_stateNxt = S_WAIT_PLL;
                end
            end
        endcase
    end

    // Status counters and irq: a clear zeroes them, an event in the same cycle still counts
    always_comb begin
        w_lossNxt     = clear_i ? 16'd0 : r_lossCount;
        w_resetCntNxt = clear_i ? 16'd0 : r_resetCount;
        w_lastLockNxt = clear_i ? 16'd0 : r_lastLockMs;
        w_irqNxt      = clear_i ? 1'b0  : r_irq;
        if (w_loss) begin
            w_lossNxt = satInc(w_lossNxt);
            w_irqNxt  = 1'b1;
        end
        if (w_timeout) begin
            w_resetCntNxt = satInc(w_resetCntNxt);
            w_irqNxt      = 1'b1;
        end
        if (w_enterUp) w_lastLockNxt = r_acqMs;
    end

    // State and output registers; reset drops any reset request in flight
    always_ff @(posedge clk_ik) begin
        if (rst_ir) begin
            r_state      <= S_WAIT_PLL;
            r_acqMs      <= '0;
            r_stableCnt  <= '0;
            r_holdCnt    <= '0;
            r_linkUp     <= 1'b0;
            r_resetReq   <= 1'b0;
            r_lossCount  <= '0;
            r_resetCount <= '0;
            r_lastLockMs <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_state      <= w_stateNxt;
            r_acqMs      <= w_acqNxt;
            r_stableCnt  <= w_stableNxt;
            r_holdCnt    <= w_holdNxt;
            r_linkUp     <= (w_stateNxt == S_UP);
            r_resetReq   <= w_timeout;
            r_lossCount  <= w_lossNxt;
            r_resetCount <= w_resetCntNxt;
            r_lastLockMs <= w_lastLockNxt;
            r_irq        <= w_irqNxt;
        end
    end

    assign link_up_o      = r_linkUp;
    assign state_o        = r_state;
    assign reset_req_o    = r_resetReq;
    assign loss_count_o   = r_lossCount;
    assign reset_count_o  = r_resetCount;
    assign last_lock_ms_o = r_lastLockMs;
    assign irq_o          = r_irq;

endmodule

// File: doc/gbt_link_supervisor.md
Name: gbt_link_supervisor

Overview:
- Sits between the GBT transceiver status (rx_ready, tx_ready, los) and the 40/120 MHz PLL, on the 120 MHz clock domain.
- Runs the link bring-up sequence and qualifies the link as UP only after a stable period.
- Issues a single-cycle reset request when acquisition times out; this request feeds the global reset path.
- Produces saturating event counters and an interrupt flag for the PS status register file.

Parameters:
- g_tick_div, 120000: clock cycles per 1 ms tick (internal free-running divider).
- g_stable_ms, 10: ticks for which link-good must hold before the link is declared UP.
- g_lock_timeout_ms, 2400: ticks allowed in ACQUIRE before a reset request.
- g_holdoff_ms, 5: ticks spent in HOLDOFF after a reset request.

Ports:
- clk_ik  input  1  120 MHz system clock.
- rst_ir  input  1  synchronous, active-high reset.
- pll_locked_i  input  1  40 MHz PLL lock.
- rx_ready_i  input  1  GBT receive ready.
- tx_ready_i  input  1  GBT transmit ready.
- los_i  input  1  optical loss of signal.
- clear_i  input  1  single-cycle pulse from PS; clears counters and irq_o.
- link_up_o  output  1  high only in UP.
- state_o  output  2  0=WAIT_PLL, 1=ACQUIRE, 2=UP, 3=HOLDOFF.
- reset_req_o  output  1  one-cycle reset request pulse.
- loss_count_o  output  16  UP-to-loss transitions, saturating at 0xFFFF.
- reset_count_o  output  16  timeout reset requests, saturating.
- last_lock_ms_o  output  16  ACQUIRE duration in ticks at the last UP entry.
- irq_o  output  1  sticky; set on any loss or reset request.

Behaviour:
- Reset values: state WAIT_PLL; every output 0; divider, tick, acquisition and stable counters 0.
- Divider: counts 0..g_tick_div-1, free-running. tick is high for one cycle when the divider equals g_tick_div-1.
- Link-good (good) = pll_locked_i & rx_ready_i & tx_ready_i & !los_i, evaluated combinationally in the current cycle.
- WAIT_PLL:
  - pll_locked_i=1 -> ACQUIRE; acq_ms and stable_cnt cleared on entry.
- ACQUIRE, evaluated each cycle in this priority:
  - !pll_locked_i -> WAIT_PLL.
  - !good -> stable_cnt <= 0.
  - good & tick -> stable_cnt++. When stable_cnt reaches g_stable_ms -> UP, and last_lock_ms_o <= acq_ms (saturated to 16 bits).
  - On tick, acq_ms++. When acq_ms reaches g_lock_timeout_ms and UP was not entered in the same cycle -> HOLDOFF, reset_req_o=1 for that one cycle, reset_count++, irq_o<=1.
  - If the stable-complete and timeout conditions occur on the same tick, UP wins.
- UP:
  - !good -> loss_count++, irq_o<=1.
  - Next state is WAIT_PLL if !pll_locked_i, otherwise ACQUIRE.
  - No reset request is issued on loss.
- HOLDOFF:
  - Counts g_holdoff_ms ticks, then -> WAIT_PLL.
  - Inputs are ignored; the block is in HOLDOFF while the external reset is being applied.
- Outputs are registered; link_up_o, state_o and reset_req_o update one cycle after the transition condition.
- Counters saturate at 0xFFFF and never wrap.
- clear_i:
  - Zeroes loss_count_o, reset_count_o, last_lock_ms_o and irq_o.
  - If an event occurs in the same cycle, the affected counter becomes 1 and irq_o ends at 1 (the event wins over the clear for irq_o).
  - Has no effect on the state machine.
- rst_ir asserted mid-operation: all state and counters return to reset values on the next clock edge, and any reset_req_o pulse in flight is dropped.

Test Plan:
All scenarios use g_tick_div=4, g_stable_ms=3, g_lock_timeout_ms=10, g_holdoff_ms=2.
- Nominal bring-up: raise pll_locked_i, then raise all good inputs 2 ticks later -> UP after 3 further ticks; link_up_o=1; last_lock_ms_o=5 (±1 by divider phase); no reset_req_o.
- Glitch during stabilisation: good for 2 ticks, drop rx_ready_i for 1 cycle, then hold good -> stable restarts; UP 3 ticks after the glitch.
- Timeout: pll_locked_i=1, rx_ready_i=0 throughout -> exactly one reset_req_o pulse after 10 ticks; reset_count_o=1; irq_o=1; HOLDOFF for 2 ticks, then WAIT_PLL -> ACQUIRE; second timeout -> reset_count_o=2.
- Loss from UP: reach UP, pulse los_i for 1 cycle -> loss_count_o=1, state ACQUIRE, irq_o=1. Drop pll_locked_i while UP -> state WAIT_PLL.
- Clear and saturation:
  - clear_i -> all counters 0, irq_o=0.
  - Force loss_count_o to 0xFFFF via 65535 losses (or backdoor) -> next loss keeps 0xFFFF.
  - clear_i coincident with a loss -> loss_count_o=1, irq_o=1.
- Reset mid-operation: assert rst_ir for 1 cycle while in UP -> next cycle state_o=0, all outputs 0.
